// File: rtl/pmips_bp_pkg.sv
// Shared constants for the PMIPSL1 branch predictor: counter encodings,
// reset/allocation counter values and the saturating statistics increment.
package pmips_bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Empty entries start weakly not-taken; fresh allocations start weakly taken.
    localparam logic [1:0] CTR_RESET = WNT;
    localparam logic [1:0] CTR_ALLOC = WT;

    localparam int PC_INC = 2;
    localparam int CNT_W  = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

endpackage

// File: rtl/pmips_sat_ctr2.sv
// 2-bit saturating up/down counter next-state function (purely combinational).
module pmips_sat_ctr2 (
    input  logic [1:0] ctr_cur,
    input  logic       taken,
    output logic [1:0] ctr_next
);
    import pmips_bp_pkg::*;

    always_comb begin
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != ST) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != SNT) ctr_next = ctr_cur - 2'd1;
        end
    end

endmodule

// File: rtl/pmips_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: asynchronous lookup for IF, training
// and mispredict/correct-PC generation from EX, plus saturating debug counters.
module pmips_branch_predictor #(
    parameter int ENTRIES = 8,
    parameter int PC_W    = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    output logic [2:0]      pred_state,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] correct_pc,
    output logic [15:0]     br_count,
    output logic [15:0]     mp_count
);
    import pmips_bp_pkg::*;

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 1 - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [15:0]        br_count_q, br_count_d;
    logic [15:0]        mp_count_q, mp_count_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [1:0]       up_ctr_next;
    logic             unused_pc_lsb;

    // Bit 0 of a PC is always zero for 16-bit instructions.
    assign unused_pc_lsb = if_pc[0] ^ upd_pc[0];

    assign lk_idx = if_pc[IDX_W:1];
    assign lk_tag = if_pc[PC_W-1:IDX_W+1];
    assign up_idx = upd_pc[IDX_W:1];
    assign up_tag = upd_pc[PC_W-1:IDX_W+1];

    // Lookup reads the registered arrays only, so a same-cycle update is never bypassed.
    assign lk_hit      = !reset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = lk_hit ? target_q[lk_idx] : '0;
    assign pred_state  = lk_hit ? {1'b1, ctr_q[lk_idx]} : 3'b000;

    assign mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_W'(PC_INC);

    assign br_count = br_count_q;
    assign mp_count = mp_count_q;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    pmips_sat_ctr2 u_sat_ctr2 (
        .ctr_cur  (ctr_q[up_idx]),
        .taken    (upd_taken),
        .ctr_next (up_ctr_next)
    );

    // upd_valid is a single-cycle strobe with no back-pressure: every cycle it
    // is high the EX stage presents exactly one resolved branch, consumed at the edge.
    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        target_d   = target_q;
        ctr_d      = ctr_q;
        br_count_d = sat_inc(br_count_q, upd_valid);
        mp_count_d = sat_inc(mp_count_q, mispredict);
        if (upd_valid) begin
            if (up_hit) begin
                ctr_d[up_idx] = up_ctr_next;
                if (upd_taken) target_d[up_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = upd_target;
                ctr_d[up_idx]    = CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            br_count_q <= '0;
            mp_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
            br_count_q <= br_count_d;
            mp_count_q <= mp_count_d;
        end
    end

endmodule

// File: tb/tb_pmips_branch_predictor.sv
// Directed self-checking bench for pmips_branch_predictor (ENTRIES=8, PC_W=16).
module tb_pmips_branch_predictor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] if_pc = '0;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic [2:0]  pred_state;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [15:0] upd_target = '0;
    logic        upd_pred_taken = 1'b0;
    logic [15:0] upd_pred_target = '0;
    logic        mispredict;
    logic [15:0] correct_pc;
    logic [15:0] br_count;
    logic [15:0] mp_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pmips_branch_predictor #(.ENTRIES(8), .PC_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .pred_state      (pred_state),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .correct_pc      (correct_pc),
        .br_count        (br_count),
        .mp_count        (mp_count)
    );

    task automatic drive_upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                             input logic ptk, input logic [15:0] ptgt);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        if_pc = 16'h0010;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
        checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL reset_pred_target: got %h expected 0000", pred_target); end
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL reset_pred_state: got %b expected 000", pred_state); end
        checks++; if (br_count !== 16'h0000) begin errors++; $display("FAIL reset_br_count: got %h expected 0000", br_count); end
        checks++; if (mp_count !== 16'h0000) begin errors++; $display("FAIL reset_mp_count: got %h expected 0000", mp_count); end
    endtask

    task automatic test_allocate();
        @(negedge clock);
        if_pc = 16'h0010;
        drive_upd(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict: got %b expected 1", mispredict); end
        checks++; if (correct_pc !== 16'h0040) begin errors++; $display("FAIL alloc_correct_pc: got %h expected 0040", correct_pc); end
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL alloc_no_bypass: got %b expected 000", pred_state); end
        @(negedge clock);
        upd_valid = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken: got %b expected 1", pred_taken); end
        checks++; if (pred_target !== 16'h0040) begin errors++; $display("FAIL alloc_pred_target: got %h expected 0040", pred_target); end
        checks++; if (pred_state !== 3'b110) begin errors++; $display("FAIL alloc_pred_state: got %b expected 110", pred_state); end
        checks++; if (mp_count !== 16'd1) begin errors++; $display("FAIL alloc_mp_count: got %0d expected 1", mp_count); end
        checks++; if (br_count !== 16'd1) begin errors++; $display("FAIL alloc_br_count: got %0d expected 1", br_count); end
    endtask

    task automatic test_not_taken();
        logic [1:0] exp_ctr [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
        logic       ptk     [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if_pc = 16'h0010;
            drive_upd(16'h0010, 1'b0, 16'h0040, ptk[i], 16'h0040);
            #1;
            checks++; if (correct_pc !== 16'h0012) begin errors++; $display("FAIL nt_correct_pc[%0d]: got %h expected 0012", i, correct_pc); end
            checks++; if (mispredict !== ptk[i]) begin errors++; $display("FAIL nt_mispredict[%0d]: got %b expected %b", i, mispredict, ptk[i]); end
            @(negedge clock);
            upd_valid = 1'b0;
            #1;
            checks++; if (pred_state !== {1'b1, exp_ctr[i]}) begin errors++; $display("FAIL nt_state[%0d]: got %b expected %b", i, pred_state, {1'b1, exp_ctr[i]}); end
            checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt_pred_taken[%0d]: got %b expected 0", i, pred_taken); end
        end
        checks++; if (br_count !== 16'd5) begin errors++; $display("FAIL nt_br_count: got %0d expected 5", br_count); end
        checks++; if (mp_count !== 16'd2) begin errors++; $display("FAIL nt_mp_count: got %0d expected 2", mp_count); end
    endtask

    task automatic test_alias();
        @(negedge clock);
        drive_upd(16'h0030, 1'b1, 16'h0080, 1'b0, 16'h0000);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispredict: got %b expected 1", mispredict); end
        @(negedge clock);
        upd_valid = 1'b0;
        if_pc = 16'h0010;
        #1;
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL alias_old_state: got %b expected 000", pred_state); end
        checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL alias_old_target: got %h expected 0000", pred_target); end
        if_pc = 16'h0030;
        #1;
        checks++; if (pred_state !== 3'b110) begin errors++; $display("FAIL alias_new_state: got %b expected 110", pred_state); end
        checks++; if (pred_target !== 16'h0080) begin errors++; $display("FAIL alias_new_target: got %h expected 0080", pred_target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_taken: got %b expected 1", pred_taken); end
    endtask

    task automatic test_wrong_target();
        @(negedge clock);
        if_pc = 16'h0030;
        drive_upd(16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0040);
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL wt_mispredict: got %b expected 1", mispredict); end
        checks++; if (correct_pc !== 16'h0050) begin errors++; $display("FAIL wt_correct_pc: got %h expected 0050", correct_pc); end
        @(negedge clock);
        upd_valid = 1'b0;
        #1;
        checks++; if (pred_target !== 16'h0050) begin errors++; $display("FAIL wt_target: got %h expected 0050", pred_target); end
        checks++; if (pred_state !== 3'b111) begin errors++; $display("FAIL wt_state: got %b expected 111", pred_state); end
    endtask

    task automatic test_back_to_back();
        // Correct prediction, then a not-taken miss, then a wrapping fall-through, on consecutive edges.
        @(negedge clock);
        drive_upd(16'h0030, 1'b1, 16'h0050, 1'b1, 16'h0050);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_correct_mp: got %b expected 0", mispredict); end
        @(negedge clock);
        checks++; if (pred_state !== 3'b111) begin errors++; $display("FAIL b2b_saturated_state: got %b expected 111", pred_state); end
        drive_upd(16'h0042, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL b2b_miss_mp: got %b expected 0", mispredict); end
        checks++; if (correct_pc !== 16'h0044) begin errors++; $display("FAIL b2b_miss_correct_pc: got %h expected 0044", correct_pc); end
        @(negedge clock);
        drive_upd(16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        checks++; if (correct_pc !== 16'h0000) begin errors++; $display("FAIL b2b_wrap_correct_pc: got %h expected 0000", correct_pc); end
        @(negedge clock);
        upd_valid = 1'b0;
        if_pc = 16'h0042;
        #1;
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL b2b_nt_miss_no_alloc: got %b expected 000", pred_state); end
        checks++; if (br_count !== 16'd10) begin errors++; $display("FAIL b2b_br_count: got %0d expected 10", br_count); end
        checks++; if (mp_count !== 16'd4) begin errors++; $display("FAIL b2b_mp_count: got %0d expected 4", mp_count); end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        if_pc = 16'h0030;
        drive_upd(16'h0030, 1'b1, 16'h0060, 1'b0, 16'h0000);
        #1;
        checks++; if (pred_state !== 3'b111) begin errors++; $display("FAIL ar_before_state: got %b expected 111", pred_state); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL ar_state: got %b expected 000", pred_state); end
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL ar_pred_taken: got %b expected 0", pred_taken); end
        checks++; if (pred_target !== 16'h0000) begin errors++; $display("FAIL ar_pred_target: got %h expected 0000", pred_target); end
        checks++; if (br_count !== 16'h0000) begin errors++; $display("FAIL ar_br_count: got %h expected 0000", br_count); end
        checks++; if (mp_count !== 16'h0000) begin errors++; $display("FAIL ar_mp_count: got %h expected 0000", mp_count); end
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL ar_mispredict: got %b expected 1", mispredict); end
        checks++; if (correct_pc !== 16'h0060) begin errors++; $display("FAIL ar_correct_pc: got %h expected 0060", correct_pc); end
        @(negedge clock);
        upd_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (pred_state !== 3'b000) begin errors++; $display("FAIL ar_update_dropped: got %b expected 000", pred_state); end
        checks++; if (br_count !== 16'h0000) begin errors++; $display("FAIL ar_br_after: got %h expected 0000", br_count); end
    endtask

    task automatic test_saturation();
        // Not-taken miss predicted taken: counts both statistics, never touches the BTB.
        @(negedge clock);
        drive_upd(16'h0042, 1'b0, 16'h0000, 1'b1, 16'h0000);
        repeat (65534) @(posedge clock);
        @(negedge clock);
        checks++; if (br_count !== 16'hFFFE) begin errors++; $display("FAIL sat_br_fffe: got %h expected fffe", br_count); end
        @(negedge clock);
        checks++; if (br_count !== 16'hFFFF) begin errors++; $display("FAIL sat_br_ffff: got %h expected ffff", br_count); end
        checks++; if (mp_count !== 16'hFFFF) begin errors++; $display("FAIL sat_mp_ffff: got %h expected ffff", mp_count); end
        @(negedge clock);
        upd_valid = 1'b0;
        #1;
        checks++; if (br_count !== 16'hFFFF) begin errors++; $display("FAIL sat_br_hold: got %h expected ffff", br_count); end
        checks++; if (mp_count !== 16'hFFFF) begin errors++; $display("FAIL sat_mp_hold: got %h expected ffff", mp_count); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_not_taken();
        test_alias();
        test_wrong_target();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
